// File: rtl/seq_chunk_adder.sv
// Multi-cycle WIDTH-bit adder: CHUNK bits per clock, low chunk first, registered carry between chunks.
// Result appears WIDTH/CHUNK edges after accept; held in DONE until out_ready, no transaction overlap.
module seq_chunk_adder #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  localparam int  CHUNK_SAFE = (CHUNK < 1) ? 1 : CHUNK;
  localparam bit  BAD_CFG    = (CHUNK < 1) || ((WIDTH % CHUNK_SAFE) != 0);
  localparam int  N          = WIDTH / CHUNK_SAFE;
  localparam int  CW         = (N > 1) ? $clog2(N) : 1;

  generate
    if (BAD_CFG) begin : g_bad_cfg
      $fatal(1, "seq_chunk_adder: WIDTH must be a positive multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           next_state;
  logic             live;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             carry;
  logic             c_out_reg;
  logic [CW-1:0]    cnt;

  logic [CHUNK-1:0] a_slice;
  logic [CHUNK-1:0] b_slice;
  logic [CHUNK:0]   chunk_sum;
  logic             last;
  logic             accept;

  // The only arithmetic path: one registered operand slice into the sum/carry registers.
  assign a_slice   = a_reg[int'(cnt)*CHUNK +: CHUNK];
  assign b_slice   = b_reg[int'(cnt)*CHUNK +: CHUNK];
  assign chunk_sum = {1'b0, a_slice} + {1'b0, b_slice} + {{CHUNK{1'b0}}, carry};
  assign last      = (cnt == CW'(N - 1));
  assign accept    = in_ready && in_valid;

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept)    next_state = RUN;
      RUN:     if (last)      next_state = DONE;
      DONE:    if (out_ready) next_state = IDLE;
      default:                next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // live keeps in_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live      <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry     <= 1'b0;
      c_out_reg <= 1'b0;
      cnt       <= '0;
    end else begin
      live <= 1'b1;
      case (state)
        IDLE: begin
          if (accept) begin
            a_reg <= a;
            b_reg <= b;
            carry <= c_in;
            cnt   <= '0;
          end
        end
        RUN: begin
          sum_reg[int'(cnt)*CHUNK +: CHUNK] <= chunk_sum[CHUNK-1:0];
          carry <= chunk_sum[CHUNK];
          cnt   <= cnt + 1'b1;
          if (last) begin
            c_out_reg <= chunk_sum[CHUNK];
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready  = live && (state == IDLE);
  assign out_valid = (state == DONE);
  assign sum       = out_valid ? sum_reg : '0;
  assign c_out     = out_valid && c_out_reg;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Bench for seq_chunk_adder at 64/4 (instance 0) and 32/8 (instance 1) against a queue-based model.
module tb_seq_chunk_adder;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        iv    [2];
  logic [63:0] a_i   [2];
  logic [63:0] b_i   [2];
  logic        ci    [2];
  logic        ordy  [2];
  wire         ir    [2];
  wire         ov    [2];
  wire         co    [2];
  wire  [63:0] sum_o [2];
  wire  [31:0] sum32;
  assign sum_o[1] = {32'b0, sum32};

  seq_chunk_adder #(.WIDTH(64), .CHUNK(4)) dut64 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[0]), .in_ready(ir[0]),
    .a(a_i[0]), .b(b_i[0]), .c_in(ci[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]),
    .sum(sum_o[0]), .c_out(co[0])
  );

  seq_chunk_adder #(.WIDTH(32), .CHUNK(8)) dut32 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[1]), .in_ready(ir[1]),
    .a(a_i[1][31:0]), .b(b_i[1][31:0]), .c_in(ci[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]),
    .sum(sum32), .c_out(co[1])
  );

  int     total = 0;
  int     bad   = 0;
  longint cyc   = 0;
  longint edges = 0;
  int     nhs  [2];
  bit     armed[2];
  bit     done [2];
  logic [64:0] expq [2][$];
  longint      dueq [2][$];

  function automatic int wd(int d);
    return (d == 0) ? 64 : 32;
  endfunction

  function automatic int nch(int d);
    return (d == 0) ? 16 : 4;
  endfunction

  function automatic logic [63:0] mask(int d);
    return (d == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  always @(posedge clk) edges <= edges + 1;

  // Model: a result becomes visible N edges after the accept edge and leaves on the handshake edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        expq[i].delete();
        dueq[i].delete();
        armed[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        bit v, r;
        v = (expq[i].size() > 0) && (cyc >= dueq[i][0]);
        r = armed[i] && (expq[i].size() == 0);
        if (v && ordy[i]) begin
          void'(expq[i].pop_front());
          void'(dueq[i].pop_front());
        end
        if (r && iv[i]) begin
          expq[i].push_back({1'b0, a_i[i]} + {1'b0, b_i[i]} + {64'b0, ci[i]});
          dueq[i].push_back(cyc + 1 + nch(i));
        end
        armed[i] = 1'b1;
      end
      cyc++;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic        ev, er, eco;
      logic [64:0] f;
      logic [63:0] es;
      ev  = (expq[i].size() > 0) && (cyc >= dueq[i][0]);
      er  = armed[i] && (expq[i].size() == 0);
      f   = ev ? expq[i][0] : 65'b0;
      es  = f[63:0] & mask(i);
      eco = ev & f[wd(i)];
      chk($sformatf("d%0d in_ready", i), {63'b0, ir[i]}, {63'b0, er});
      chk($sformatf("d%0d out_valid", i), {63'b0, ov[i]}, {63'b0, ev});
      chk($sformatf("d%0d sum", i), sum_o[i], es);
      chk($sformatf("d%0d c_out", i), {63'b0, co[i]}, {63'b0, eco});
      if (ov[i] && ordy[i]) nhs[i]++;
    end
  end

  task automatic send(int d, logic [63:0] av, logic [63:0] bv, logic cv);
    int n = 0;
    while (!ir[d] && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!ir[d]) begin
      total++;
      bad++;
      $display("FAIL d%0d send timeout: in_ready=%b required 1", d, ir[d]);
    end else begin
      iv[d]  = 1'b1;
      a_i[d] = av & mask(d);
      b_i[d] = bv & mask(d);
      ci[d]  = cv;
      @(negedge clk);
      iv[d]  = 1'b0;
    end
  endtask

  task automatic wait_ov(int d, output int lat);
    int     n  = 0;
    longint e0 = edges;
    while (!ov[d] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ov[d]) begin
      total++;
      bad++;
      $display("FAIL d%0d out_valid timeout: got 0, required 1", d);
    end
    lat = int'(edges - e0);
  endtask

  task automatic drain(int d);
    ordy[d] = 1'b1;
    @(negedge clk);
    ordy[d] = 1'b0;
  endtask

  task automatic rand_run(int d);
    logic [63:0] av, bv;
    logic        cv;
    int          n = 0;
    for (int k = 0; k < 1000; k++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      av = {$urandom, $urandom};
      bv = {$urandom, $urandom};
      cv = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) begin
        av = 64'hFFFF_FFFF_FFFF_FFFF;
        bv = 64'h0;
        cv = 1'b1;
      end
      send(d, av, bv, cv);
    end
    while (nhs[d] < 1000 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("d%0d results delivered", d), 64'(nhs[d]), 64'd1000);
    chk($sformatf("d%0d model drained", d), 64'(expq[d].size()), 64'd0);
    done[d] = 1'b1;
  endtask

  // Stall pattern changes just after posedge so the handshake count reads a settled out_ready.
  task automatic stall(int d);
    while (!done[d]) begin
      @(posedge clk);
      #1 ordy[d] = ($urandom_range(0, 2) != 0);
    end
    ordy[d] = 1'b0;
  endtask

  initial begin
    #950000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int  lat;
    bit  seen;
    for (int i = 0; i < 2; i++) begin
      iv[i] = 1'b0; a_i[i] = '0; b_i[i] = '0; ci[i] = 1'b0; ordy[i] = 1'b0;
      nhs[i] = 0; done[i] = 1'b0;
    end

    repeat (3) @(negedge clk);
    chk("reset in_ready", {63'b0, ir[0]}, 64'd0);
    rst_n = 1'b1;
    #1 chk("in_ready before first edge", {63'b0, ir[0]}, 64'd0);
    @(negedge clk);
    chk("in_ready after first edge", {63'b0, ir[0]}, 64'd1);

    send(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1);
    wait_ov(0, lat);
    chk("wrap latency", 64'(lat), 64'd16);
    chk("wrap sum", sum_o[0], 64'h0);
    chk("wrap c_out", {63'b0, co[0]}, 64'd1);
    drain(0);

    send(0, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b0);
    wait_ov(0, lat);
    for (int k = 0; k < 5; k++) begin
      chk("stall sum", sum_o[0], 64'hFFFF_FFFF_FFFF_FFFF);
      chk("stall c_out", {63'b0, co[0]}, 64'd0);
      chk("stall in_ready", {63'b0, ir[0]}, 64'd0);
      @(negedge clk);
    end
    drain(0);
    chk("single-cycle out_valid", {63'b0, ov[0]}, 64'd0);

    send(0, 64'd100, 64'd23, 1'b0);
    iv[0] = 1'b1; a_i[0] = 64'd999; b_i[0] = 64'd1; ci[0] = 1'b1;
    repeat (4) @(negedge clk);
    iv[0] = 1'b0;
    wait_ov(0, lat);
    chk("ignored in_valid sum", sum_o[0], 64'd123);
    chk("in_ready in DONE", {63'b0, ir[0]}, 64'd0);
    drain(0);
    chk("in_ready after handshake", {63'b0, ir[0]}, 64'd1);

    send(0, 64'd1, 64'd1, 1'b0);
    wait_ov(0, lat);
    chk("pre-reset sum", sum_o[0], 64'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset out_valid", {63'b0, ov[0]}, 64'd0);
    chk("async reset sum", sum_o[0], 64'd0);
    chk("async reset in_ready", {63'b0, ir[0]}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("release in_ready before edge", {63'b0, ir[0]}, 64'd0);
    @(negedge clk);
    chk("release in_ready after edge", {63'b0, ir[0]}, 64'd1);

    send(0, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
    repeat (7) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("mid-run reset out_valid", {63'b0, ov[0]}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ordy[0] = 1'b1;
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (ov[0]) seen = 1'b1;
    end
    ordy[0] = 1'b0;
    chk("discarded result never valid", {63'b0, seen}, 64'd0);
    send(0, 64'd5, 64'd7, 1'b1);
    wait_ov(0, lat);
    chk("post-reset sum", sum_o[0], 64'd13);
    chk("post-reset c_out", {63'b0, co[0]}, 64'd0);
    drain(0);

    send(1, 64'hFFFF_FFFF, 64'h0, 1'b1);
    wait_ov(1, lat);
    chk("d1 latency", 64'(lat), 64'd4);
    chk("d1 wrap sum", sum_o[1], 64'h0);
    chk("d1 wrap c_out", {63'b0, co[1]}, 64'd1);
    drain(1);

    nhs[0] = 0;
    nhs[1] = 0;
    fork
      rand_run(0);
      rand_run(1);
      stall(0);
      stall(1);
    join

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
